// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the elastic pipeline stage
package pipe_pkg;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        bd;
  } pipe_entry_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - payload register with load, clear-to-bubble and nop-on-exception
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int               PC_W    = 32,
  parameter int               INSTR_W = 32,
  parameter int               EXC_W   = 5,
  parameter logic [PC_W-1:0]  RST_PC  = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic               i_clear_pc_en,
  input  logic [PC_W-1:0]    i_clear_pc,
  input  logic [PC_W-1:0]    i_pc,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [EXC_W-1:0]   i_exc,
  input  logic               i_bd,
  output logic [PC_W-1:0]    o_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic [EXC_W-1:0]   o_exc,
  output logic               o_bd
);

  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [EXC_W-1:0]   r_exc;
  logic               r_bd;

  // Clear wins over load so a flush always leaves a bubble; excepting entries are stored as nops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RST_PC;
      r_instr <= '0;
      r_exc   <= '0;
      r_bd    <= 1'b0;
    end else if (i_clear) begin
      r_instr <= '0;
      r_exc   <= '0;
      r_bd    <= 1'b0;
      if (i_clear_pc_en) r_pc <= i_clear_pc;
    end else if (i_load) begin
      r_pc    <= i_pc;
      r_instr <= (i_exc != '0) ? '0 : i_instr;
      r_exc   <= i_exc;
      r_bd    <= i_bd;
    end
  end

  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_exc   = r_exc;
  assign o_bd    = r_bd;

endmodule

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - elastic pipeline stage with 2-entry skid buffer, flush and stall counter
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter int              EXC_W    = 5,
  parameter int              CNT_W    = 16,
  parameter logic [PC_W-1:0] RESET_PC = pipe_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [EXC_W-1:0]   in_exc,
  input  logic               in_bd,
  input  logic               flush,
  input  logic [PC_W-1:0]    flush_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [EXC_W-1:0]   out_exc,
  output logic               out_bd,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cnt
);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_stall;

  logic               w_acc;
  logic               w_ret;
  logic               w_main_load;
  logic               w_main_from_skid;
  logic               w_main_clear;
  logic               w_skid_load;
  logic               w_skid_clear;

  logic [PC_W-1:0]    w_skid_pc;
  logic [INSTR_W-1:0] w_skid_instr;
  logic [EXC_W-1:0]   w_skid_exc;
  logic               w_skid_bd;

  // in_ready comes only from registered state so downstream stalls never ripple upstream combinationally.
  assign in_ready  = (r_state != FULL) && !reset;
  assign out_valid = (r_state != EMPTY);
  assign occupancy = r_state;
  assign stall_cnt = r_stall;
  assign w_acc     = in_valid && in_ready;
  assign w_ret     = out_valid && out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_next;
  end

  // Next state and payload steering; flush discards both held entries and anything accepted now.
  always_comb begin
    w_next           = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_main_clear     = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;
    if (flush) begin
      w_next       = EMPTY;
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_acc) begin
            w_next      = ONE;
            w_main_load = 1'b1;
          end
        end
        ONE: begin
          if (w_acc && !w_ret) begin
            w_next      = FULL;
            w_skid_load = 1'b1;
          end else if (w_acc && w_ret) begin
            w_main_load = 1'b1;
          end else if (w_ret) begin
            w_next       = EMPTY;
            w_main_clear = 1'b1;
          end
        end
        FULL: begin
          if (w_ret) begin
            w_next           = ONE;
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clear     = 1'b1;
          end
        end
        default: w_next = EMPTY;
      endcase
    end
  end

  // Saturating count of cycles where a valid entry is held back by downstream.
  always_ff @(posedge clk) begin
    if (reset)                                       r_stall <= '0;
    else if (out_valid && !out_ready && r_stall != '1) r_stall <= r_stall + 1'b1;
  end

  pipe_entry_reg #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .EXC_W(EXC_W), .RST_PC(RESET_PC)
  ) u_main (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_main_load),
    .i_clear      (w_main_clear),
    .i_clear_pc_en(flush),
    .i_clear_pc   (flush_pc),
    .i_pc         (w_main_from_skid ? w_skid_pc    : in_pc),
    .i_instr      (w_main_from_skid ? w_skid_instr : in_instr),
    .i_exc        (w_main_from_skid ? w_skid_exc   : in_exc),
    .i_bd         (w_main_from_skid ? w_skid_bd    : in_bd),
    .o_pc         (out_pc),
    .o_instr      (out_instr),
    .o_exc        (out_exc),
    .o_bd         (out_bd)
  );

  pipe_entry_reg #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .EXC_W(EXC_W), .RST_PC('0)
  ) u_skid (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_skid_load),
    .i_clear      (w_skid_clear),
    .i_clear_pc_en(1'b0),
    .i_clear_pc   ('0),
    .i_pc         (in_pc),
    .i_instr      (in_instr),
    .i_exc        (in_exc),
    .i_bd         (in_bd),
    .o_pc         (w_skid_pc),
    .o_instr      (w_skid_instr),
    .o_exc        (w_skid_exc),
    .o_bd         (w_skid_bd)
  );

endmodule
